// File: rtl/csa_pipe_adder_pkg.sv
// Shared defaults and helpers for the pipelined carry-select adder/subtractor.
package csa_pipe_adder_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_SEG   = 4;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   function automatic int unsigned csa_stages(input int unsigned width, input int unsigned seg);
      return width / seg;
   endfunction

endpackage

// File: rtl/csa_pipe_adder_seg.sv
// One carry-select segment: two ripple chains (carry-in 0 and 1) and an output mux.
module csa_seg
   import csa_pipe_adder_pkg::*;
#(
   parameter int unsigned SEG = DEF_SEG
) (
   input  logic [SEG-1:0] x,
   input  logic [SEG-1:0] y,
   input  logic           cin,
   output logic [SEG-1:0] s,
   output logic           cout
);

   logic [SEG-1:0] w_s0;
   logic [SEG-1:0] w_s1;
   logic [SEG:0]   w_c0;
   logic [SEG:0]   w_c1;

   always_comb begin
      w_s0    = '0;
      w_s1    = '0;
      w_c0    = '0;
      w_c1    = '0;
      w_c1[0] = 1'b1;
      for (int unsigned i = 0; i < SEG; i++) begin
         w_s0[i]   = x[i] ^ y[i] ^ w_c0[i];
         w_c0[i+1] = (x[i] & y[i]) | (w_c0[i] & (x[i] ^ y[i]));
         w_s1[i]   = x[i] ^ y[i] ^ w_c1[i];
         w_c1[i+1] = (x[i] & y[i]) | (w_c1[i] & (x[i] ^ y[i]));
      end
   end

   assign s    = cin ? w_s1 : w_s0;
   assign cout = cin ? w_c1[SEG] : w_c0[SEG];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment resolves per stage,
// valid/ready handshake with full backpressure on both sides.
module csa_pipe_adder
   import csa_pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SEG   = DEF_SEG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int unsigned N = csa_stages(WIDTH, SEG);

   op_e              w_op;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin;
   logic [N-1:0]     w_v;
   logic [N-1:0]     w_rdy;

   assign w_op    = sub ? OP_SUB : OP_ADD;
   assign w_b_eff = (w_op == OP_SUB) ? ~b : b;
   assign w_cin   = (w_op == OP_SUB) ? 1'b1 : ci;

   for (genvar k = 0; k < N; k++) begin : g_stage
      localparam int unsigned LO = k * SEG;
      localparam int unsigned UW = WIDTH - LO;

      logic [UW-1:0]     w_a_in;
      logic [UW-1:0]     w_b_in;
      logic              w_ci;
      logic              w_v_in;
      logic [SEG-1:0]    w_seg_s;
      logic              w_seg_co;
      logic [LO+SEG-1:0] w_s_out;
      logic [LO+SEG-1:0] r_s;
      logic              r_c;
      logic              r_v;

      // Closed form of rdy[k] = !v[k] || rdy[k+1], avoiding a self-referencing vector.
      assign w_rdy[k] = out_ready | ~(&w_v[N-1:k]);
      assign w_v[k]   = r_v;

      if (k == 0) begin : g_first
         assign w_a_in  = a;
         assign w_b_in  = w_b_eff;
         assign w_ci    = w_cin;
         assign w_v_in  = in_valid;
         assign w_s_out = w_seg_s;
      end else begin : g_next
         assign w_a_in  = g_stage[k-1].g_fwd.r_a;
         assign w_b_in  = g_stage[k-1].g_fwd.r_b;
         assign w_ci    = g_stage[k-1].r_c;
         assign w_v_in  = g_stage[k-1].r_v;
         assign w_s_out = {w_seg_s, g_stage[k-1].r_s};
      end

      csa_seg #(.SEG(SEG)) u_seg (
         .x    (w_a_in[SEG-1:0]),
         .y    (w_b_in[SEG-1:0]),
         .cin  (w_ci),
         .s    (w_seg_s),
         .cout (w_seg_co)
      );

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_v <= 1'b0;
            r_c <= 1'b0;
            r_s <= '0;
         end else if (w_rdy[k]) begin
            r_v <= w_v_in;
            r_c <= w_seg_co;
            r_s <= w_s_out;
         end
      end

      if (k < N - 1) begin : g_fwd
         logic [UW-SEG-1:0] r_a;
         logic [UW-SEG-1:0] r_b;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_rdy[k]) begin
               r_a <= w_a_in[UW-1:SEG];
               r_b <= w_b_in[UW-1:SEG];
            end
         end
      end else begin : g_last
         logic r_ovf;

         // The last segment holds the operand sign bits, so overflow resolves here.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_ovf <= 1'b0;
            end else if (w_rdy[k]) begin
               r_ovf <= (w_a_in[SEG-1] == w_b_in[SEG-1]) && (w_seg_s[SEG-1] != w_a_in[SEG-1]);
            end
         end
      end
   end

   assign in_ready  = w_rdy[0];
   assign out_valid = w_v[N-1];
   assign sum       = g_stage[N-1].r_s;
   assign co        = g_stage[N-1].r_c;
   assign ovf       = g_stage[N-1].g_last.r_ovf;

endmodule
